// File: rtl/mastermind_pkg.sv
// Shared types and widths for the Mastermind scoreboard slice.
package mastermind_pkg;

    localparam int PEG_W  = 3;
    localparam int CODE_W = 12;

    typedef enum logic [1:0] {
        ST_PLAYING,
        ST_WON,
        ST_LOST
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] guess;
        logic [PEG_W-1:0]  red;
        logic [PEG_W-1:0]  white;
    } hist_entry_t;

endpackage

// File: rtl/feedback_history.sv
// Eight-entry round history: one write port, one registered read port, synchronous clear.
module feedback_history
    import mastermind_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  hist_entry_t wr_data,
    input  logic [2:0]  rd_addr,
    input  logic        rd_valid,
    output hist_entry_t rd_data
);

    hist_entry_t mem [8];

    // Read samples the array before this edge's write, so a same-index read sees old data.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= rd_valid ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/mastermind_scoreboard.sv
// Round bookkeeping after the peg comparator: win/loss FSM, round counter, feedback history.
module mastermind_scoreboard
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = 8,
    parameter int PEGS        = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                result_valid,
    input  logic [PEG_W-1:0]    red,
    input  logic [PEG_W-1:0]    white,
    input  logic [CODE_W-1:0]   guess,
    input  logic                new_game,
    input  logic [2:0]          hist_sel,
    output logic                accept_guess,
    output logic                won,
    output logic                lost,
    output logic [3:0]          guess_count,
    output logic [PEG_W-1:0]    last_red,
    output logic [PEG_W-1:0]    last_white,
    output logic [PEG_W-1:0]    hist_red,
    output logic [PEG_W-1:0]    hist_white,
    output logic [CODE_W-1:0]   hist_guess,
    output logic                fb_error
);

    localparam logic [3:0]       MAX_CNT = 4'(MAX_GUESSES);
    localparam logic [3:0]       PEGS4   = 4'(PEGS);
    localparam logic [PEG_W-1:0] PEGS3   = PEG_W'(PEGS);

    state_t      state;
    state_t      next_state;
    logic        result_legal;
    logic        record;
    logic        reject;
    logic [3:0]  count_inc;
    logic        rd_valid;
    hist_entry_t wr_entry;
    hist_entry_t rd_entry;

    // Sum is taken at 4 bits so 3-bit overflow cannot disguise an illegal pair.
    assign result_legal = ({1'b0, red} <= PEGS4) && (({1'b0, red} + {1'b0, white}) <= PEGS4);
    assign count_inc    = guess_count + 4'd1;
    assign rd_valid     = ({1'b0, hist_sel} < guess_count);
    assign wr_entry     = '{guess: guess, red: red, white: white};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_PLAYING;
        end else begin
            state <= next_state;
        end
    end

    // new_game outranks everything, including a result arriving in the same cycle.
    always_comb begin
        next_state = state;
        record     = 1'b0;
        reject     = 1'b0;
        if (new_game) begin
            next_state = ST_PLAYING;
        end else begin
            case (state)
                ST_PLAYING: begin
                    if (result_valid) begin
                        if (!result_legal) begin
                            reject = 1'b1;
                        end else begin
                            record = 1'b1;
                            if (red == PEGS3) begin
                                next_state = ST_WON;
                            end else if (count_inc == MAX_CNT) begin
                                next_state = ST_LOST;
                            end
                        end
                    end
                end
                ST_WON:  next_state = ST_WON;
                ST_LOST: next_state = ST_LOST;
                default: next_state = ST_PLAYING;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || new_game) begin
            guess_count <= '0;
            last_red    <= '0;
            last_white  <= '0;
            fb_error    <= 1'b0;
        end else begin
            if (record) begin
                guess_count <= count_inc;
                last_red    <= red;
                last_white  <= white;
            end
            if (reject) begin
                fb_error <= 1'b1;
            end
        end
    end

    // Status flags are flopped from the next state so they change with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            accept_guess <= 1'b1;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            accept_guess <= (next_state == ST_PLAYING);
            won          <= (next_state == ST_WON);
            lost         <= (next_state == ST_LOST);
        end
    end

    feedback_history u_history (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (new_game),
        .wr_en    (record),
        .wr_addr  (guess_count[2:0]),
        .wr_data  (wr_entry),
        .rd_addr  (hist_sel),
        .rd_valid (rd_valid),
        .rd_data  (rd_entry)
    );

    assign hist_red   = rd_entry.red;
    assign hist_white = rd_entry.white;
    assign hist_guess = rd_entry.guess;

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Directed self-checking bench for mastermind_scoreboard with hand-computed expectations.
module tb_mastermind_scoreboard;

    logic        clk;
    logic        resetn;
    logic        result_valid;
    logic [2:0]  red;
    logic [2:0]  white;
    logic [11:0] guess;
    logic        new_game;
    logic [2:0]  hist_sel;
    logic        accept_guess;
    logic        won;
    logic        lost;
    logic [3:0]  guess_count;
    logic [2:0]  last_red;
    logic [2:0]  last_white;
    logic [2:0]  hist_red;
    logic [2:0]  hist_white;
    logic [11:0] hist_guess;
    logic        fb_error;

    int total = 0;
    int bad   = 0;

    mastermind_scoreboard #(.MAX_GUESSES(8), .PEGS(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .result_valid (result_valid),
        .red          (red),
        .white        (white),
        .guess        (guess),
        .new_game     (new_game),
        .hist_sel     (hist_sel),
        .accept_guess (accept_guess),
        .won          (won),
        .lost         (lost),
        .guess_count  (guess_count),
        .last_red     (last_red),
        .last_white   (last_white),
        .hist_red     (hist_red),
        .hist_white   (hist_white),
        .hist_guess   (hist_guess),
        .fb_error     (fb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge too.
    task automatic send(input logic [2:0] r, input logic [2:0] w, input logic [11:0] g);
        @(negedge clk);
        result_valid = 1'b1; red = r; white = w; guess = g;
        @(negedge clk);
        result_valid = 1'b0; red = '0; white = '0; guess = '0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic read_hist(input logic [2:0] sel);
        @(negedge clk);
        hist_sel = sel;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; result_valid = 1'b0; red = '0; white = '0; guess = '0;
        new_game = 1'b0; hist_sel = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        total++; if (accept_guess !== 1'b1) begin bad++; $display("[TB] FAIL reset_accept got=%b exp=1", accept_guess); end
        total++; if (won !== 1'b0 || lost !== 1'b0) begin bad++; $display("[TB] FAIL reset_won_lost got=%b%b exp=00", won, lost); end
        total++; if (guess_count !== 4'd0 || fb_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_count_err got=%0d/%b exp=0/0", guess_count, fb_error); end
        total++; if (last_red !== 3'd0 || last_white !== 3'd0) begin bad++; $display("[TB] FAIL reset_last got=%0d/%0d exp=0/0", last_red, last_white); end
        total++; if (hist_red !== 3'd0 || hist_white !== 3'd0 || hist_guess !== 12'd0) begin bad++; $display("[TB] FAIL reset_hist got=%0d/%0d/%h exp=0/0/000", hist_red, hist_white, hist_guess); end
    endtask

    task automatic test_history();
        send(3'd1, 3'd2, 12'h123);
        send(3'd0, 3'd0, 12'h456);
        send(3'd2, 3'd1, 12'h701);
        total++; if (guess_count !== 4'd3) begin bad++; $display("[TB] FAIL hist_count got=%0d exp=3", guess_count); end
        total++; if (accept_guess !== 1'b1 || won !== 1'b0 || lost !== 1'b0) begin bad++; $display("[TB] FAIL hist_playing got=%b%b%b exp=100", accept_guess, won, lost); end
        total++; if (last_red !== 3'd2 || last_white !== 3'd1) begin bad++; $display("[TB] FAIL hist_last got=%0d/%0d exp=2/1", last_red, last_white); end
        read_hist(3'd0);
        total++; if (hist_guess !== 12'h123 || hist_red !== 3'd1 || hist_white !== 3'd2) begin bad++; $display("[TB] FAIL hist_e0 got=%h/%0d/%0d exp=123/1/2", hist_guess, hist_red, hist_white); end
        read_hist(3'd1);
        total++; if (hist_guess !== 12'h456 || hist_red !== 3'd0 || hist_white !== 3'd0) begin bad++; $display("[TB] FAIL hist_e1 got=%h/%0d/%0d exp=456/0/0", hist_guess, hist_red, hist_white); end
        read_hist(3'd2);
        total++; if (hist_guess !== 12'h701 || hist_red !== 3'd2 || hist_white !== 3'd1) begin bad++; $display("[TB] FAIL hist_e2 got=%h/%0d/%0d exp=701/2/1", hist_guess, hist_red, hist_white); end
        read_hist(3'd3);
        total++; if (hist_guess !== 12'h000 || hist_red !== 3'd0) begin bad++; $display("[TB] FAIL hist_e3_empty got=%h/%0d exp=000/0", hist_guess, hist_red); end
        read_hist(3'd5);
        total++; if (hist_guess !== 12'h000 || hist_white !== 3'd0) begin bad++; $display("[TB] FAIL hist_e5_empty got=%h/%0d exp=000/0", hist_guess, hist_white); end
    endtask

    task automatic test_win();
        pulse_new_game();
        send(3'd1, 3'd1, 12'h111);
        send(3'd4, 3'd0, 12'h222);
        total++; if (won !== 1'b1 || accept_guess !== 1'b0 || lost !== 1'b0) begin bad++; $display("[TB] FAIL win_flags got=w%b a%b l%b exp=w1 a0 l0", won, accept_guess, lost); end
        total++; if (guess_count !== 4'd2 || last_red !== 3'd4) begin bad++; $display("[TB] FAIL win_count got=%0d/%0d exp=2/4", guess_count, last_red); end
        send(3'd2, 3'd2, 12'h333);
        total++; if (guess_count !== 4'd2 || last_red !== 3'd4 || last_white !== 3'd0 || won !== 1'b1) begin bad++; $display("[TB] FAIL win_frozen got=%0d/%0d/%0d/%b exp=2/4/0/1", guess_count, last_red, last_white, won); end
    endtask

    task automatic test_loss();
        pulse_new_game();
        for (int i = 0; i < 7; i++) send(3'd1, 3'd1, 12'(i));
        total++; if (guess_count !== 4'd7 || lost !== 1'b0 || accept_guess !== 1'b1) begin bad++; $display("[TB] FAIL loss_seven got=%0d/%b/%b exp=7/0/1", guess_count, lost, accept_guess); end
        send(3'd3, 3'd0, 12'h777);
        total++; if (lost !== 1'b1 || won !== 1'b0 || accept_guess !== 1'b0) begin bad++; $display("[TB] FAIL loss_flags got=l%b w%b a%b exp=l1 w0 a0", lost, won, accept_guess); end
        total++; if (guess_count !== 4'd8) begin bad++; $display("[TB] FAIL loss_count got=%0d exp=8", guess_count); end
        pulse_new_game();
        for (int i = 0; i < 7; i++) send(3'd0, 3'd1, 12'(i));
        send(3'd4, 3'd0, 12'h888);
        total++; if (won !== 1'b1 || lost !== 1'b0 || guess_count !== 4'd8) begin bad++; $display("[TB] FAIL last_round_win got=w%b l%b c%0d exp=w1 l0 c8", won, lost, guess_count); end
    endtask

    task automatic test_illegal();
        pulse_new_game();
        send(3'd1, 3'd0, 12'h0a1);
        send(3'd3, 3'd2, 12'h0b2);
        total++; if (fb_error !== 1'b1 || guess_count !== 4'd1 || last_red !== 3'd1) begin bad++; $display("[TB] FAIL illegal_sum got=e%b c%0d r%0d exp=e1 c1 r1", fb_error, guess_count, last_red); end
        send(3'd5, 3'd0, 12'h0c3);
        total++; if (guess_count !== 4'd1 || won !== 1'b0 || accept_guess !== 1'b1) begin bad++; $display("[TB] FAIL illegal_red got=c%0d w%b a%b exp=c1 w0 a1", guess_count, won, accept_guess); end
        send(3'd2, 3'd2, 12'h0d4);
        total++; if (guess_count !== 4'd2 || last_white !== 3'd2 || fb_error !== 1'b1) begin bad++; $display("[TB] FAIL illegal_then_legal got=c%0d w%0d e%b exp=c2 w2 e1", guess_count, last_white, fb_error); end
        read_hist(3'd1);
        total++; if (hist_guess !== 12'h0d4 || hist_red !== 3'd2 || hist_white !== 3'd2) begin bad++; $display("[TB] FAIL illegal_hist got=%h/%0d/%0d exp=0d4/2/2", hist_guess, hist_red, hist_white); end
    endtask

    task automatic test_new_game_collision();
        pulse_new_game();
        send(3'd3, 3'd3, 12'hfff);
        for (int i = 0; i < 8; i++) send(3'd0, 3'd0, 12'h010);
        total++; if (lost !== 1'b1 || fb_error !== 1'b1) begin bad++; $display("[TB] FAIL coll_setup got=l%b e%b exp=l1 e1", lost, fb_error); end
        @(negedge clk);
        new_game = 1'b1; result_valid = 1'b1; red = 3'd1; white = 3'd1; guess = 12'habc;
        @(negedge clk);
        new_game = 1'b0; result_valid = 1'b0; red = '0; white = '0; guess = '0;
        total++; if (accept_guess !== 1'b1 || lost !== 1'b0 || won !== 1'b0) begin bad++; $display("[TB] FAIL coll_state got=a%b l%b w%b exp=a1 l0 w0", accept_guess, lost, won); end
        total++; if (guess_count !== 4'd0 || fb_error !== 1'b0 || last_red !== 3'd0) begin bad++; $display("[TB] FAIL coll_cleared got=c%0d e%b r%0d exp=c0 e0 r0", guess_count, fb_error, last_red); end
        send(3'd2, 3'd0, 12'h321);
        read_hist(3'd0);
        total++; if (hist_guess !== 12'h321 || hist_red !== 3'd2 || guess_count !== 4'd1) begin bad++; $display("[TB] FAIL coll_no_write got=%h/%0d/%0d exp=321/2/1", hist_guess, hist_red, guess_count); end
    endtask

    task automatic test_back_to_back();
        pulse_new_game();
        @(negedge clk);
        hist_sel = 3'd0;
        result_valid = 1'b1; red = 3'd1; white = 3'd0; guess = 12'h5a5;
        @(negedge clk);
        red = 3'd2; white = 3'd0; guess = 12'h6b6;
        @(negedge clk);
        red = 3'd0; white = 3'd3; guess = 12'h7c7; hist_sel = 3'd2;
        @(negedge clk);
        result_valid = 1'b0; red = '0; white = '0; guess = '0;
        total++; if (guess_count !== 4'd3 || last_white !== 3'd3) begin bad++; $display("[TB] FAIL b2b_count got=%0d/%0d exp=3/3", guess_count, last_white); end
        total++; if (hist_guess !== 12'h000 || hist_white !== 3'd0) begin bad++; $display("[TB] FAIL b2b_same_cycle_read got=%h/%0d exp=000/0", hist_guess, hist_white); end
        @(negedge clk);
        total++; if (hist_guess !== 12'h7c7 || hist_white !== 3'd3) begin bad++; $display("[TB] FAIL b2b_next_cycle_read got=%h/%0d exp=7c7/3", hist_guess, hist_white); end
        read_hist(3'd1);
        total++; if (hist_guess !== 12'h6b6 || hist_red !== 3'd2) begin bad++; $display("[TB] FAIL b2b_e1 got=%h/%0d exp=6b6/2", hist_guess, hist_red); end
    endtask

    task automatic test_reset_mid();
        pulse_new_game();
        send(3'd1, 3'd1, 12'h101);
        send(3'd3, 3'd1, 12'h202);
        send(3'd5, 3'd0, 12'h303);
        send(3'd0, 3'd2, 12'h404);
        send(3'd2, 3'd2, 12'h505);
        read_hist(3'd1);
        total++; if (guess_count !== 4'd4 || hist_guess !== 12'h202 || fb_error !== 1'b1) begin bad++; $display("[TB] FAIL mid_setup got=c%0d g%h e%b exp=c4 g202 e1", guess_count, hist_guess, fb_error); end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        total++; if (accept_guess !== 1'b1 || won !== 1'b0 || lost !== 1'b0 || fb_error !== 1'b0) begin bad++; $display("[TB] FAIL mid_flags got=a%b w%b l%b e%b exp=a1 w0 l0 e0", accept_guess, won, lost, fb_error); end
        total++; if (guess_count !== 4'd0 || last_red !== 3'd0 || last_white !== 3'd0) begin bad++; $display("[TB] FAIL mid_counts got=%0d/%0d/%0d exp=0/0/0", guess_count, last_red, last_white); end
        total++; if (hist_guess !== 12'h000 || hist_red !== 3'd0 || hist_white !== 3'd0) begin bad++; $display("[TB] FAIL mid_hist got=%h/%0d/%0d exp=000/0/0", hist_guess, hist_red, hist_white); end
        @(negedge clk);
        total++; if (hist_guess !== 12'h000) begin bad++; $display("[TB] FAIL mid_hist_later got=%h exp=000", hist_guess); end
    endtask

    initial begin
        test_reset();
        test_history();
        test_win();
        test_loss();
        test_illegal();
        test_new_game_collision();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
